// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared widths, types and the operand read/bypass helper for the
// architectural register file.
//   REG_NUM    : number of architectural registers (x0 reads as zero)
//   REG_WIDTH  : register index width
//   DATA_WIDTH : register value width
//   ROB_WIDTH  : ROB id width (id 0 is never allocated, so 0 means "no tag")
package reg_file_pkg;

   localparam int REG_NUM    = 32;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam int ROB_WIDTH  = 4;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [REG_WIDTH-1:0]  reg_idx_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ROB_WIDTH-1:0]  rob_id_t;

   typedef struct packed {
      logic    busy;
      data_t   val;
      rob_id_t rob;
   } read_port_t;

   // Operand read with commit bypass. A commit to the same register always
   // forwards its value. It only releases the busy bit when it is the youngest
   // producer; otherwise a later rename still owns the register.
   function automatic read_port_t read_bypass(
      input reg_idx_t idx,
      input data_t    stored_val,
      input logic     stored_busy,
      input rob_id_t  stored_tag,
      input logic     commit,
      input reg_idx_t commit_dest,
      input data_t    commit_val,
      input rob_id_t  commit_id
   );
      read_port_t rp;
      rp.busy = stored_busy;
      rp.val  = stored_val;
      rp.rob  = stored_tag;
      if (idx == '0) begin
         rp.busy = FALSE;
         rp.val  = '0;
         rp.rob  = '0;
      end else if (commit && commit_dest == idx) begin
         rp.val = commit_val;
         if (stored_tag == commit_id) begin
            rp.busy = FALSE;
         end
      end
      return rp;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if
// Bundles the dispatcher operand-read/rename port, the ROB commit port and
// the flush line seen by the register file.
//   master : dispatcher / ROB side (drives indices, renames, commits)
//   slave  : register file side (returns operand busy/value/tag)
interface reg_file_if;
   import reg_file_pkg::*;

   reg_idx_t rs1_dp_in;
   reg_idx_t rs2_dp_in;
   logic     rs1_busy_dp_out;
   data_t    rs1_val_dp_out;
   rob_id_t  rs1_rob_dp_out;
   logic     rs2_busy_dp_out;
   data_t    rs2_val_dp_out;
   rob_id_t  rs2_rob_dp_out;

   logic     rename_dp_in;
   reg_idx_t rd_dp_in;
   rob_id_t  rob_id_dp_in;

   logic     rdy_commit_rob_in;
   reg_idx_t dest_rob_in;
   data_t    value_rob_in;
   rob_id_t  rob_id_rob_in;

   logic     refresh_cdb_in;

   modport master (
      output rs1_dp_in, rs2_dp_in, rename_dp_in, rd_dp_in, rob_id_dp_in,
             rdy_commit_rob_in, dest_rob_in, value_rob_in, rob_id_rob_in,
             refresh_cdb_in,
      input  rs1_busy_dp_out, rs1_val_dp_out, rs1_rob_dp_out,
             rs2_busy_dp_out, rs2_val_dp_out, rs2_rob_dp_out
   );

   modport slave (
      input  rs1_dp_in, rs2_dp_in, rename_dp_in, rd_dp_in, rob_id_dp_in,
             rdy_commit_rob_in, dest_rob_in, value_rob_in, rob_id_rob_in,
             refresh_cdb_in,
      output rs1_busy_dp_out, rs1_val_dp_out, rs1_rob_dp_out,
             rs2_busy_dp_out, rs2_val_dp_out, rs2_rob_dp_out
   );

endinterface

// File: rtl/reg_file.sv
// reg_file
// Architectural register file with per-register rename tags.
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset (clears values, busy bits, tags)
//   rdy_in   : global enable; low freezes all state, reads stay live
//   bus      : reg_file_if.slave -- operand reads, rename, commit, flush
module reg_file
   import reg_file_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rdy_in,
   reg_file_if.slave  bus
);

   data_t              value_q [REG_NUM];
   rob_id_t            tag_q   [REG_NUM];
   logic [REG_NUM-1:0] busy_q;

   read_port_t rp1;
   read_port_t rp2;

   // Later assignments win within the edge: commit tag-clear, then rename,
   // then flush. The commit value write is never cancelled by a flush.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else if (rdy_in) begin
         if (bus.rdy_commit_rob_in && bus.dest_rob_in != '0) begin
            value_q[bus.dest_rob_in] <= bus.value_rob_in;
            if (tag_q[bus.dest_rob_in] == bus.rob_id_rob_in) begin
               busy_q[bus.dest_rob_in] <= FALSE;
               tag_q[bus.dest_rob_in]  <= '0;
            end
         end
         if (bus.rename_dp_in && bus.rd_dp_in != '0 && !bus.refresh_cdb_in) begin
            busy_q[bus.rd_dp_in] <= TRUE;
            tag_q[bus.rd_dp_in]  <= bus.rob_id_dp_in;
         end
         if (bus.refresh_cdb_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
               tag_q[i] <= '0;
            end
         end
      end
   end

   // Reads ignore a same-cycle rename: sources are read before rd is renamed.
   always_comb begin
      rp1 = read_bypass(bus.rs1_dp_in, value_q[bus.rs1_dp_in], busy_q[bus.rs1_dp_in],
                        tag_q[bus.rs1_dp_in], bus.rdy_commit_rob_in, bus.dest_rob_in,
                        bus.value_rob_in, bus.rob_id_rob_in);
      rp2 = read_bypass(bus.rs2_dp_in, value_q[bus.rs2_dp_in], busy_q[bus.rs2_dp_in],
                        tag_q[bus.rs2_dp_in], bus.rdy_commit_rob_in, bus.dest_rob_in,
                        bus.value_rob_in, bus.rob_id_rob_in);
   end

   assign bus.rs1_busy_dp_out = rp1.busy;
   assign bus.rs1_val_dp_out  = rp1.val;
   assign bus.rs1_rob_dp_out  = rp1.rob;
   assign bus.rs2_busy_dp_out = rp2.busy;
   assign bus.rs2_val_dp_out  = rp2.val;
   assign bus.rs2_rob_dp_out  = rp2.rob;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
// Directed self-checking bench for reg_file: rename, commit bypass, stale
// commit, commit+rename collision, flush, x0, enable gating, async reset.
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk;
   logic rst_n;
   logic rdy;
   int   n_assert;
   int   n_fail;

   reg_file_if bus ();

   reg_file dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .rdy_in   (rdy),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rename_dp_in      = 1'b0;
      bus.rd_dp_in          = '0;
      bus.rob_id_dp_in      = '0;
      bus.rdy_commit_rob_in = 1'b0;
      bus.dest_rob_in       = '0;
      bus.value_rob_in      = '0;
      bus.rob_id_rob_in     = '0;
      bus.refresh_cdb_in    = 1'b0;
   endtask

   task automatic rename(input int rd, input int id);
      bus.rename_dp_in = 1'b1;
      bus.rd_dp_in     = reg_idx_t'(rd);
      bus.rob_id_dp_in = rob_id_t'(id);
   endtask

   task automatic commit(input int dest, input logic [31:0] val, input int id);
      bus.rdy_commit_rob_in = 1'b1;
      bus.dest_rob_in       = reg_idx_t'(dest);
      bus.value_rob_in      = val;
      bus.rob_id_rob_in     = rob_id_t'(id);
   endtask

   task automatic rd1(input int r);
      bus.rs1_dp_in = reg_idx_t'(r);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      rdy      = 1'b1;
      bus.rs1_dp_in = '0;
      bus.rs2_dp_in = '0;
      idle();
      #12;
      rst_n = 1'b1;
      tick();

      // reset state
      rd1(5);
      chk("rst_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("rst_val",  bus.rs1_val_dp_out, 32'd0);

      // rename x5 -> ROB 3; same-cycle read unaffected
      rename(5, 3);
      #1;
      chk("ren_same_cycle_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      tick();
      idle();
      #1;
      chk("ren_busy", 32'(bus.rs1_busy_dp_out), 32'd1);
      chk("ren_rob",  32'(bus.rs1_rob_dp_out), 32'd3);

      // commit (x5, 0x1234, ROB 3): bypass then stored
      commit(5, 32'h1234, 3);
      #1;
      chk("byp_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("byp_val",  bus.rs1_val_dp_out, 32'h1234);
      tick();
      idle();
      #1;
      chk("cmt_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("cmt_val",  bus.rs1_val_dp_out, 32'h1234);

      // stale commit on x7 (rob 2 then rob 4), read through rs2
      rename(7, 2);
      tick();
      rename(7, 4);
      tick();
      idle();
      bus.rs2_dp_in = 5'd7;
      commit(7, 32'hAA, 2);
      #1;
      chk("stale_byp_val",  bus.rs2_val_dp_out, 32'hAA);
      chk("stale_byp_busy", 32'(bus.rs2_busy_dp_out), 32'd1);
      tick();
      idle();
      #1;
      chk("stale_val",  bus.rs2_val_dp_out, 32'hAA);
      chk("stale_busy", 32'(bus.rs2_busy_dp_out), 32'd1);
      chk("stale_rob",  32'(bus.rs2_rob_dp_out), 32'd4);

      // commit and rename to x9 in the same cycle
      rename(9, 6);
      tick();
      commit(9, 32'h55, 6);
      rename(9, 8);
      tick();
      idle();
      rd1(9);
      chk("coll_val",  bus.rs1_val_dp_out, 32'h55);
      chk("coll_busy", 32'(bus.rs1_busy_dp_out), 32'd1);
      chk("coll_rob",  32'(bus.rs1_rob_dp_out), 32'd8);

      // refresh with concurrent commit to x1 and rename of x2
      for (int r = 1; r <= 4; r++) begin
         rename(r, r);
         tick();
      end
      idle();
      rd1(4);
      chk("pre_ref_busy4", 32'(bus.rs1_busy_dp_out), 32'd1);
      bus.refresh_cdb_in = 1'b1;
      commit(1, 32'h10, 1);
      rename(2, 9);
      tick();
      idle();
      rd1(1);
      chk("ref_x1_val",  bus.rs1_val_dp_out, 32'h10);
      chk("ref_x1_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      rd1(2);
      chk("ref_x2_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("ref_x2_rob",  32'(bus.rs1_rob_dp_out), 32'd0);
      rd1(4);
      chk("ref_x4_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      rd1(7);
      chk("ref_x7_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      rd1(9);
      chk("ref_x9_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("ref_x9_val",  bus.rs1_val_dp_out, 32'h55);

      // x0 is never written or renamed
      rename(0, 5);
      commit(0, 32'hFFFF, 5);
      rd1(0);
      chk("x0_byp_val",  bus.rs1_val_dp_out, 32'd0);
      chk("x0_byp_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      tick();
      idle();
      #1;
      chk("x0_val",  bus.rs1_val_dp_out, 32'd0);
      chk("x0_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      chk("x0_rob",  32'(bus.rs1_rob_dp_out), 32'd0);

      // rdy low freezes everything, including refresh
      rename(11, 5);
      tick();
      idle();
      rdy = 1'b0;
      bus.refresh_cdb_in = 1'b1;
      rename(10, 7);
      commit(5, 32'hBEEF, 1);
      tick();
      idle();
      rdy = 1'b1;
      rd1(11);
      chk("hold_x11_busy", 32'(bus.rs1_busy_dp_out), 32'd1);
      chk("hold_x11_rob",  32'(bus.rs1_rob_dp_out), 32'd5);
      rd1(10);
      chk("hold_x10_busy", 32'(bus.rs1_busy_dp_out), 32'd0);
      rd1(5);
      chk("hold_x5_val",   bus.rs1_val_dp_out, 32'h1234);

      // asynchronous reset mid-cycle, no clock edge in between
      bus.rs2_dp_in = 5'd11;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_x5_val",   bus.rs1_val_dp_out, 32'd0);
      chk("arst_x11_busy", 32'(bus.rs2_busy_dp_out), 32'd0);
      chk("arst_x11_rob",  32'(bus.rs2_rob_dp_out), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer's commit port and beside the dispatcher.
- Holds 32 committed values and, per register, a busy bit plus the ROB id of the youngest in-flight producer.
- Dispatcher reads operands (value, or pending ROB tag) and renames rd. ROB commits retire values and clear tags. A pipeline refresh drops all tags.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
REG_WIDTH, 5, register index width
DATA_WIDTH, 32, register value width
ROB_WIDTH, 4, ROB id width; id 0 is never allocated (ROB ids run 1..2^ROB_WIDTH-1)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; when low, no state changes
rs1_dp_in  input  REG_WIDTH  dispatcher source 1 index
rs2_dp_in  input  REG_WIDTH  dispatcher source 2 index
rs1_busy_dp_out  output  1  rs1 awaits an in-flight producer
rs1_val_dp_out  output  DATA_WIDTH  rs1 committed value (valid when not busy)
rs1_rob_dp_out  output  ROB_WIDTH  rs1 producer ROB id (valid when busy)
rs2_busy_dp_out, rs2_val_dp_out, rs2_rob_dp_out  output  1/DATA_WIDTH/ROB_WIDTH  same for rs2
rename_dp_in  input  1  dispatcher allocates rd this cycle
rd_dp_in  input  REG_WIDTH  destination being renamed
rob_id_dp_in  input  ROB_WIDTH  ROB entry allocated to rd
rdy_commit_rob_in  input  1  ROB commits a register write
dest_rob_in  input  REG_WIDTH  committed destination
value_rob_in  input  DATA_WIDTH  committed value
rob_id_rob_in  input  ROB_WIDTH  ROB id of committing entry
refresh_cdb_in  input  1  misprediction flush

Behaviour:
- Reset (rst_n_in low, immediate, independent of clock): all values 0, all busy 0, all tags 0. The read outputs are combinational, so they read 0 / not busy / tag 0.
- All sequential updates occur on a rising clk_in edge with rdy_in high. With rdy_in low, state holds and reads stay live.
- Read path (0 latency, combinational): busy/val/rob reflect stored state plus a commit bypass.
  - If rdy_commit_rob_in, dest_rob_in == rsX != 0 and stored tag[rsX] == rob_id_rob_in: busy=0 and val=value_rob_in.
  - If the tag does not match, only val is bypassed and busy stays 1.
  - rsX == 0 always gives val 0, busy 0, rob 0.
  - Same-cycle rename does NOT affect reads: the dispatcher reads its sources before renaming its own rd.
- Commit (rdy_commit_rob_in, dest != 0): value[dest] <= value_rob_in.
  - busy[dest] is cleared only if tag[dest] == rob_id_rob_in; a younger rename keeps the register busy.
- Rename (rename_dp_in, rd != 0, no refresh): busy[rd] <= 1, tag[rd] <= rob_id_dp_in.
  - Commit and rename to the same register in one cycle: the value is written and the rename wins (busy=1, new tag).
- Refresh (refresh_cdb_in): all busy <= 0 and all tags <= 0.
  - Any concurrent commit value write is still performed, since the flushing instruction itself may write rd.
  - Concurrent rename is ignored.
  - Refresh has priority over rename and rename has priority over commit tag-clear.
- Writes or renames to x0 are ignored; x0 is never busy.
- Tag reuse: ROB ids wrap. A stale matching tag cannot occur because the ROB never reallocates an id before commit; no extra checking is required.

Decomposition:
- Shared define.vh: DATA_WIDTH, REG_WIDTH, ROB_WIDTH, REG_NUM, TRUE/FALSE.
- Single flat module; no sub-module needed.

Test Plan:
- Reset: drive rst_n_in low mid-cycle after writes -> all reads return val 0, busy 0, immediately without a clock edge.
- Rename x5 to ROB 3, next cycle read rs1=5 -> busy 1, rob 3. Commit (x5, 0x1234, rob 3) -> same-cycle read busy 0, val 0x1234. Next cycle stored busy 0.
- Stale commit: rename x7 to ROB 2, then to ROB 4. Commit (x7, 0xAA, rob 2) -> val 0xAA stored, busy stays 1, rob 4.
- Same-cycle commit and rename: x9 tag 6, commit (x9, 0x55, rob 6) with rename x9 -> ROB 8 -> after edge val 0x55, busy 1, tag 8.
- Refresh: rename x1..x4 busy, assert refresh with commit (x1, 0x10, rob of x1) and rename x2 -> all busy 0, x1 = 0x10, x2 not renamed.
- x0: rename x0 and commit (x0, 0xFFFF) -> reads of x0 give val 0, busy 0. rdy_in low blocks all updates.
